// File: rtl/aes192_round_key_sequencer.sv
// rtl/aes192_round_key_sequencer.sv - captures AES-192 round keys from the key schedule and streams them out in order
// Optional feature macro: KEYSEQ_ZEROIZE_EN (clears key storage on done, abort and reset).
module aes192_round_key_sequencer #(
    parameter int NR    = 12,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dec_mode,
    input  logic [255:0]     key_in,
    output logic [255:0]     ks_key,
    output logic [IDX_W-1:0] ks_i,
    input  logic [127:0]     ks_rk,
    output logic [127:0]     rk_data,
    output logic [IDX_W-1:0] rk_round,
    output logic             rk_last,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2
    } state_e;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NR);

    state_e           state_q, state_d;
    logic [191:0]     key_reg_q, key_reg_d;
    logic             dec_q, dec_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             mem_we;
    logic [127:0]     mem_q [0:NR];

    logic unused_key_tail;
    assign unused_key_tail = ^key_in[63:0];

    logic handshake;
    assign handshake = (state_q == S_EMIT) && rk_ready;

`ifdef KEYSEQ_ZEROIZE_EN
    logic zeroize;
    assign zeroize = abort || (handshake && (count_q == LAST));
`endif

    always_comb begin
        state_d   = state_q;
        key_reg_d = key_reg_q;
        dec_d     = dec_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            ptr_d   = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        key_reg_d = key_in[255:64];
                        dec_d     = dec_mode;
                        idx_d     = '0;
                        state_d   = S_FILL;
                    end
                end
                S_FILL: begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = S_EMIT;
                        idx_d   = '0;
                        ptr_d   = dec_q ? LAST : '0;
                        count_d = '0;
                    end
                end
                S_EMIT: begin
                    if (rk_ready) begin
                        // Pointer freezes on the final key so it never wraps past 0 or NR.
                        if (count_q == LAST) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            ptr_d   = dec_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef KEYSEQ_ZEROIZE_EN
        if (zeroize) begin
            key_reg_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            key_reg_q <= '0;
            dec_q     <= 1'b0;
            idx_q     <= '0;
            ptr_q     <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_reg_q <= key_reg_d;
            dec_q     <= dec_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            done_q    <= done_d;
        end
    end

`ifdef KEYSEQ_ZEROIZE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) mem_q[i] <= '0;
        end else if (zeroize) begin
            for (int i = 0; i <= NR; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[idx_q] <= ks_rk;
        end
    end

    assign ks_key = (state_q == S_IDLE) ? '0 : {key_reg_q, 64'h0};
`else
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= ks_rk;
        end
    end

    assign ks_key = {key_reg_q, 64'h0};
`endif

    assign ks_i     = (state_q == S_FILL) ? idx_q : '0;
    assign rk_valid = (state_q == S_EMIT);
    assign rk_data  = rk_valid ? mem_q[ptr_q] : '0;
    assign rk_round = rk_valid ? ptr_q : '0;
    assign rk_last  = rk_valid && (count_q == LAST);
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

endmodule
